// File: rtl/icache_tag_req_arb_if.sv
`default_nettype none
// ============================================================================
// icache_tag_req_arb_if : snoop / fetch / prefetch request ports and tag-array
// request port of the icache tag request arbiter.   Rev 1.0
// ============================================================================
interface icache_tag_req_arb_if #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 20
);
    // Payload layout (pc_req_t): {opcode[1:0], addr.tag[TAG_W-1:0], addr.index[INDEX_W-1:0]}
    localparam int PLD_W = 2 + TAG_W + INDEX_W;

    logic               snp_vld;
    logic               snp_rdy;
    logic [TAG_W-1:0]   snp_tag;
    logic [INDEX_W-1:0] snp_index;

    logic               fet_vld;
    logic               fet_rdy;
    logic [TAG_W-1:0]   fet_tag;
    logic [INDEX_W-1:0] fet_index;

    logic               pf_vld;
    logic               pf_rdy;
    logic [TAG_W-1:0]   pf_tag;
    logic [INDEX_W-1:0] pf_index;

    logic               tag_req_vld;
    logic               tag_req_rdy;
    logic [PLD_W-1:0]   tag_req_pld;
    logic [1:0]         tag_req_src;
    logic [15:0]        hazard_cnt;

    modport master (
        output snp_vld, snp_tag, snp_index,
        output fet_vld, fet_tag, fet_index,
        output pf_vld,  pf_tag,  pf_index,
        output tag_req_rdy,
        input  snp_rdy, fet_rdy, pf_rdy,
        input  tag_req_vld, tag_req_pld, tag_req_src, hazard_cnt
    );

    modport slave (
        input  snp_vld, snp_tag, snp_index,
        input  fet_vld, fet_tag, fet_index,
        input  pf_vld,  pf_tag,  pf_index,
        input  tag_req_rdy,
        output snp_rdy, fet_rdy, pf_rdy,
        output tag_req_vld, tag_req_pld, tag_req_src, hazard_cnt
    );
endinterface
`default_nettype wire

// File: rtl/icache_tag_req_arb.sv
`default_nettype none
// ============================================================================
// icache_tag_req_arb : 3-way tag-array request arbiter with index-hazard
// masking, grant lock under back-pressure and prefetch anti-starvation. Rev 1.0
// ============================================================================
module icache_tag_req_arb #(
    parameter int INDEX_W    = 6,
    parameter int TAG_W      = 20,
    parameter int STARVE_MAX = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    icache_tag_req_arb_if.slave    i_bus
);
    localparam int PLD_W = 2 + TAG_W + INDEX_W;

    localparam logic [1:0] c_SRC_SNP  = 2'd0;
    localparam logic [1:0] c_SRC_FET  = 2'd1;
    localparam logic [1:0] c_SRC_PF   = 2'd2;
    localparam logic [1:0] c_SRC_NONE = 2'd3;

    localparam logic [1:0] c_DOWNSTREAM_OPCODE = 2'b01;
    localparam logic [1:0] c_UPSTREAM_OPCODE   = 2'b10;
    localparam logic [1:0] c_PREFETCH_OPCODE   = 2'b11;

    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_MAX);

    logic               r_lock;
    logic [1:0]         r_lock_src;
    logic               r_inf_vld;
    logic [INDEX_W-1:0] r_inf_idx;
    logic [3:0]         r_starve;
    logic [15:0]        r_hazard_cnt;

    logic               w_snp_hit, w_fet_hit, w_pf_hit;
    logic               w_snp_elig, w_fet_elig, w_pf_elig;
    logic               w_mask_any;
    logic [1:0]         w_src;
    logic               w_vld;
    logic               w_acc;
    logic [1:0]         w_opc;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;

    // A source hitting the index accepted last cycle would race its read-modify-write.
    assign w_snp_hit  = r_inf_vld && (i_bus.snp_index == r_inf_idx);
    assign w_fet_hit  = r_inf_vld && (i_bus.fet_index == r_inf_idx);
    assign w_pf_hit   = r_inf_vld && (i_bus.pf_index  == r_inf_idx);
    assign w_snp_elig = i_bus.snp_vld && !w_snp_hit;
    assign w_fet_elig = i_bus.fet_vld && !w_fet_hit;
    assign w_pf_elig  = i_bus.pf_vld  && !w_pf_hit;

    assign w_mask_any = (i_bus.snp_vld && w_snp_hit && !(r_lock && r_lock_src == c_SRC_SNP)) ||
                        (i_bus.fet_vld && w_fet_hit && !(r_lock && r_lock_src == c_SRC_FET)) ||
                        (i_bus.pf_vld  && w_pf_hit  && !(r_lock && r_lock_src == c_SRC_PF));

    // Reset gates the grant combinationally so outputs idle while rst_n is low.
    always_comb begin
        w_src = c_SRC_NONE;
        if (!rst_n)
            w_src = c_SRC_NONE;
        else if (r_lock)
            w_src = r_lock_src;
        else if (w_pf_elig && (r_starve == c_STARVE_MAX))
            w_src = c_SRC_PF;
        else if (w_snp_elig)
            w_src = c_SRC_SNP;
        else if (w_fet_elig)
            w_src = c_SRC_FET;
        else if (w_pf_elig)
            w_src = c_SRC_PF;
    end

    always_comb begin
        w_opc = 2'b00;
        w_tag = '0;
        w_idx = '0;
        case (w_src)
            c_SRC_SNP: begin
                w_opc = c_DOWNSTREAM_OPCODE;
                w_tag = i_bus.snp_tag;
                w_idx = i_bus.snp_index;
            end
            c_SRC_FET: begin
                w_opc = c_UPSTREAM_OPCODE;
                w_tag = i_bus.fet_tag;
                w_idx = i_bus.fet_index;
            end
            c_SRC_PF: begin
                w_opc = c_PREFETCH_OPCODE;
                w_tag = i_bus.pf_tag;
                w_idx = i_bus.pf_index;
            end
            default: ;
        endcase
    end

    assign w_vld = (w_src != c_SRC_NONE);
    assign w_acc = w_vld && i_bus.tag_req_rdy;

    assign i_bus.tag_req_vld = w_vld;
    assign i_bus.tag_req_src = w_src;
    assign i_bus.tag_req_pld = PLD_W'({w_opc, w_tag, w_idx});
    assign i_bus.snp_rdy     = w_acc && (w_src == c_SRC_SNP);
    assign i_bus.fet_rdy     = w_acc && (w_src == c_SRC_FET);
    assign i_bus.pf_rdy      = w_acc && (w_src == c_SRC_PF);
    assign i_bus.hazard_cnt  = r_hazard_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock       <= 1'b0;
            r_lock_src   <= c_SRC_NONE;
            r_inf_vld    <= 1'b0;
            r_inf_idx    <= '0;
            r_starve     <= 4'd0;
            r_hazard_cnt <= 16'd0;
        end else begin
            r_inf_vld <= w_acc;
            if (w_acc)
                r_inf_idx <= w_idx;

            if (w_acc) begin
                r_lock <= 1'b0;
            end else if (w_vld) begin
                r_lock     <= 1'b1;
                r_lock_src <= w_src;
            end

            if (!i_bus.pf_vld || (w_acc && w_src == c_SRC_PF))
                r_starve <= 4'd0;
            else if (w_acc && (r_starve != c_STARVE_MAX))
                r_starve <= r_starve + 4'd1;

            if (w_mask_any)
                r_hazard_cnt <= r_hazard_cnt + 16'd1;
        end
    end
endmodule
`default_nettype wire

// File: doc/icache_tag_req_arb.md
ICACHE_TAG_REQ_ARB -- requirements
Module: icache_tag_req_arb

Interface
REQ-001 SHALL have parameter INDEX_W, default ICACHE_INDEX_WIDTH, tag-array index width.
REQ-002 SHALL have parameter TAG_W, default ICACHE_TAG_WIDTH, address tag width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, cycles a prefetch may lose before promotion (range 1..15).
REQ-004 clk  input  1  clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 snp_vld / snp_rdy  input / output  1 / 1  downstream snoop request handshake.
REQ-007 snp_tag, snp_index  input  TAG_W, INDEX_W  snoop address.
REQ-008 fet_vld / fet_rdy  input / output  1 / 1  upstream fetch-miss request handshake.
REQ-009 fet_tag, fet_index  input  TAG_W, INDEX_W  fetch address.
REQ-010 pf_vld / pf_rdy  input / output  1 / 1  prefetch request handshake.
REQ-011 pf_tag, pf_index  input  TAG_W, INDEX_W  prefetch address.
REQ-012 tag_req_vld  output  1  request to tag-array controller.
REQ-013 tag_req_rdy  input  1  controller ready (low during tag write or stall).
REQ-014 tag_req_pld  output  pc_req_t  opcode plus addr.tag/addr.index of granted source.
REQ-015 tag_req_src  output  2  granted source: 0 snoop, 1 fetch, 2 prefetch, 3 none.
REQ-016 hazard_cnt  output  16  count of cycles any valid request was masked by index hazard.

Function
REQ-017 Transfer on any port SHALL occur only when its vld and rdy are both high at a rising clk edge.
REQ-018 Requesters hold vld and address stable until accepted; block SHALL NOT drop or duplicate requests.
REQ-019 Opcode SHALL be DOWNSTREAM_OPCODE for snoop, UPSTREAM_OPCODE for fetch, PREFETCH_OPCODE for prefetch.
REQ-020 Base priority SHALL be snoop > fetch > prefetch among eligible sources.
REQ-021 When starve_cnt == STARVE_MAX and prefetch eligible, prefetch SHALL take highest priority.
REQ-022 In-flight register: on each accept SHALL capture index, valid for exactly the next cycle, else invalid.
REQ-023 Source SHALL be ineligible in a cycle where in-flight valid and its index equals in-flight index (read-modify-write hazard).
REQ-024 tag_req_vld SHALL be high iff a source is locked or any source eligible; SHALL NOT depend combinationally on tag_req_rdy.
REQ-025 tag_req_pld/src SHALL reflect the granted source; src = 3 and pld = 0 when tag_req_vld low.
REQ-026 Exactly one of snp_rdy/fet_rdy/pf_rdy SHALL equal tag_req_vld && tag_req_rdy for the granted source; others 0.
REQ-027 If tag_req_vld && !tag_req_rdy, grant SHALL lock; next cycle same source and payload presented regardless of newly arriving higher-priority requests.
REQ-028 Lock SHALL clear on the cycle the locked request is accepted; a locked request is not subject to hazard masking.
REQ-029 starve_cnt (4 bit): +1 per cycle with pf_vld high, another source accepted, saturating at STARVE_MAX.
REQ-030 starve_cnt SHALL clear to 0 on prefetch accept or whenever pf_vld low.
REQ-031 hazard_cnt SHALL increment by 1 per cycle where >=1 valid unlocked source is masked by REQ-023; wraps 0xFFFF->0.
REQ-032 Throughput: one accept per cycle when tag_req_rdy held high and requests use distinct indices.

Reset
REQ-033 During rst_n low: tag_req_vld, all *_rdy 0; tag_req_src 3; pld 0; lock, in-flight cleared; starve_cnt, hazard_cnt 0.
REQ-034 Reset mid-lock SHALL discard the lock; first cycle after release arbitrates afresh.

Verification
REQ-035 snp, fet, pf all valid, indices 1/2/3, rdy=1 -> accepts in order snoop, fetch, prefetch on 3 consecutive cycles.
REQ-036 fet index 5 accepted, next cycle fet index 5 and pf index 6 valid -> pf accepted, hazard_cnt=1; fetch accepted the cycle after.
REQ-037 pf valid with continuous snp/fet traffic distinct indices, STARVE_MAX=4 -> pf accepted on 5th cycle, starve_cnt then 0.
REQ-038 pf granted, tag_req_rdy=0 for 3 cycles, snoop arrives cycle 1 -> pf payload stable 3 cycles, pf accepted before snoop.
REQ-039 rst_n asserted while locked with requests pending -> all outputs reset values immediately; after release snoop wins.
